// File: rtl/seg7_frame_decoder.sv
// Reads back a multiplexed dual 7-segment bus and reconstructs the 0-99 score as a one-cycle strobe.
// Optional macro SEG7_BLANK_TENS_EN: a blank tens digit (0x00) decodes as 0.
module seg7_frame_decoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg,
  input  logic [1:0] dig_en,
  output logic [6:0] score,
  output logic       score_valid,
  output logic       seg_err
);

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_UNITS,
    WAIT_TENS,
    EMIT
  } state_t;

  state_t      state_q, state_d;
  logic [8:0]  smp_q, smp_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        armed_q, armed_d;
  logic [3:0]  u_q, u_d;
  logic [3:0]  t_q, t_d;
  logic [6:0]  score_q, score_d;
  logic        score_valid_q, score_valid_d;
  logic        seg_err_q, seg_err_d;

  logic [8:0]  in_w;
  logic        changed;
  logic        cap;
  logic        is_tens;
  logic        dec_valid;
  logic [3:0]  dec_digit;

  always_comb begin
    in_w    = {dig_en, seg};
    changed = (in_w != smp_q);
    smp_d   = in_w;
    if (changed) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
    cap     = (cnt_q == CNT_MAX) && armed_q && (smp_q[8] ^ smp_q[7]);
    // An input change must win over the capture clear, or the new pattern could never capture.
    if (changed) begin
      armed_d = 1'b1;
    end else if (cap) begin
      armed_d = 1'b0;
    end else begin
      armed_d = armed_q;
    end
    is_tens = smp_q[8];
  end

  always_comb begin
    dec_valid = 1'b1;
    dec_digit = '0;
    case (smp_q[6:0])
      7'h3F: dec_digit = 4'd0;
      7'h06: dec_digit = 4'd1;
      7'h5B: dec_digit = 4'd2;
      7'h4F: dec_digit = 4'd3;
      7'h66: dec_digit = 4'd4;
      7'h6D: dec_digit = 4'd5;
      7'h7D: dec_digit = 4'd6;
      7'h07: dec_digit = 4'd7;
      7'h7F: dec_digit = 4'd8;
      7'h6F: dec_digit = 4'd9;
`ifdef SEG7_BLANK_TENS_EN
      7'h00: dec_valid = (smp_q[8:7] == 2'b10);
`endif
      default: dec_valid = 1'b0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    u_d           = u_q;
    t_d           = t_q;
    score_d       = score_q;
    score_valid_d = 1'b0;
    seg_err_d     = seg_err_q;
    case (state_q)
      WAIT_UNITS: begin
        if (cap && dec_valid && !is_tens) begin
          u_d     = dec_digit;
          state_d = WAIT_TENS;
        end
      end
      WAIT_TENS: begin
        if (cap && dec_valid) begin
          if (is_tens) begin
            t_d     = dec_digit;
            state_d = EMIT;
          end else begin
            u_d = dec_digit;
          end
        end
      end
      EMIT: begin
        score_d       = 7'(t_q) * 7'd10 + 7'(u_q);
        score_valid_d = 1'b1;
        state_d       = WAIT_UNITS;
      end
      default: state_d = WAIT_UNITS;
    endcase
    if (cap && !dec_valid) begin
      seg_err_d = 1'b1;
      if (state_q != EMIT) begin
        state_d = WAIT_UNITS;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= WAIT_UNITS;
      smp_q         <= '0;
      cnt_q         <= '0;
      armed_q       <= 1'b1;
      u_q           <= '0;
      t_q           <= '0;
      score_q       <= '0;
      score_valid_q <= 1'b0;
      seg_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      smp_q         <= smp_d;
      cnt_q         <= cnt_d;
      armed_q       <= armed_d;
      u_q           <= u_d;
      t_q           <= t_d;
      score_q       <= score_d;
      score_valid_q <= score_valid_d;
      seg_err_q     <= seg_err_d;
    end
  end

  assign score       = score_q;
  assign score_valid = score_valid_q;
  assign seg_err     = seg_err_q;

endmodule
